// File: rtl/i2s_tx.sv
// ---------------------------------------------------------------------------
// i2s_tx -- I2S bus-master transmitter (Philips format)
//
// Takes stereo sample pairs over a valid/ready handshake into a one-deep
// holding register. It serializes each pair MSB-first, one channel per slot
// of SLOT bit clocks. The bit clock (sck), word select (ws) and serial data
// (sd) are all generated from the single system clock.
//
// Parameters
//   WIDTH  sample bits per channel (1..SLOT)
//   SLOT   sck periods per channel slot (WIDTH..64); frame = 2*SLOT periods
//   DIV    system clocks per sck half-period (>= 1)
//
// Ports
//   clock     in   system clock, all logic on the rising edge
//   reset     in   asynchronous reset, active low
//   enable    in   serializer run; low freezes divider, sck, ws, sd, bit index
//   tx_left   in   left sample, two's complement
//   tx_right  in   right sample, two's complement
//   tx_valid  in   sample pair valid
//   tx_ready  out  holding register empty
//   sck       out  I2S bit clock, 2*DIV system clocks per period
//   ws        out  word select, 0 = left, 1 = right
//   sd        out  serial data, changes only on sck falling
//   underrun  out  one-clock pulse when a frame starts with nothing held
// ---------------------------------------------------------------------------
module i2s_tx #(
  parameter int WIDTH = 24,
  parameter int SLOT  = 24,
  parameter int DIV   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] tx_left,
  input  logic [WIDTH-1:0] tx_right,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             sck,
  output logic             ws,
  output logic             sd,
  output logic             underrun
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(2 * SLOT + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(2 * SLOT - 1);
  localparam logic [BW-1:0] WS_FIRST = BW'(SLOT - 1);
  localparam logic [BW-1:0] WS_LAST  = BW'(2 * SLOT - 2);
  localparam logic [BW-1:0] L_END    = BW'(WIDTH);
  localparam logic [BW-1:0] R_FIRST  = BW'(SLOT);
  localparam logic [BW-1:0] R_END    = BW'(SLOT + WIDTH);

  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_idx;
  logic [BW-1:0]    next_idx;
  logic             full;
  logic [WIDTH-1:0] hold_left;
  logic [WIDTH-1:0] hold_right;
  logic [WIDTH-1:0] left_sh;
  logic [WIDTH-1:0] right_sh;
  logic [WIDTH-1:0] left_shifted;
  logic [WIDTH-1:0] right_shifted;
  logic [WIDTH-1:0] load_left;
  logic [WIDTH-1:0] load_right;
  logic             tick;
  logic             advance;
  logic             frame_start;
  logic             accept;

  assign tx_ready = !full;

  // Event decode. A tick is the enabled clock on which sck toggles; when sck
  // is currently high that toggle is a falling edge, which is the moment the
  // serializer moves on to the next bit period. The frame boundary is the
  // advance that wraps the bit index back to 0. An empty holding register at
  // the boundary sends a frame of zeros rather than stale data.
  always_comb begin
    tick          = enable && (div_cnt == DIV_LAST);
    advance       = tick && sck;
    frame_start   = advance && (bit_idx == IDX_LAST);
    next_idx      = (bit_idx == IDX_LAST) ? '0 : bit_idx + BW'(1);
    accept        = tx_valid && !full;
    left_shifted  = left_sh << 1;
    right_shifted = right_sh << 1;
    load_left     = full ? hold_left  : '0;
    load_right    = full ? hold_right : '0;
  end

  // Bit-clock divider. The counter and sck only move while enabled, so a
  // pause stretches the current sck phase without producing a runt pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (enable) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        sck     <= ~sck;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  // Holding register. The frame load empties it, and a handshake fills it.
  // Both can occur on the same clock only when the register was already
  // empty at the boundary. In that case the new pair waits for the next
  // frame instead of bypassing into the current one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full       <= 1'b0;
      hold_left  <= '0;
      hold_right <= '0;
    end else begin
      if (frame_start) begin
        full <= 1'b0;
      end
      if (accept) begin
        full       <= 1'b1;
        hold_left  <= tx_left;
        hold_right <= tx_right;
      end
    end
  end

  // Serializer. ws and sd are registered on the sck falling edge for the
  // period being entered (next_idx), so they stay stable across the
  // following rising edge where the receiver samples them. ws goes high one
  // period before the right MSB and drops one period before the left MSB.
  // The left register shifts through the left slot. The right register is
  // held until its slot begins and then shifts through it. Bit index resets
  // to the last period so the first advance after reset is a frame load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_idx  <= IDX_LAST;
      ws       <= 1'b0;
      sd       <= 1'b0;
      left_sh  <= '0;
      right_sh <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= frame_start && !full;
      if (advance) begin
        bit_idx <= next_idx;
        ws      <= (next_idx >= WS_FIRST) && (next_idx <= WS_LAST);
        if (frame_start) begin
          left_sh  <= load_left;
          right_sh <= load_right;
          sd       <= load_left[WIDTH-1];
        end else if (next_idx < L_END) begin
          left_sh <= left_shifted;
          sd      <= left_shifted[WIDTH-1];
        end else if (next_idx == R_FIRST) begin
          sd <= right_sh[WIDTH-1];
        end else if ((next_idx > R_FIRST) && (next_idx < R_END)) begin
          right_sh <= right_shifted;
          sd       <= right_shifted[WIDTH-1];
        end else begin
          sd <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx -- self-checking bench for i2s_tx
//
// dut_a: WIDTH=24, SLOT=24, DIV=1. It covers reset behaviour, the handshake,
//        sustained streaming, underrun frames, the same-clock load/handshake
//        case, freezing with enable low, and asynchronous reset mid-frame.
// dut_b: WIDTH=24, SLOT=32, DIV=2. It covers slot padding and sck/frame
//        timing.
//
// A monitor samples each DUT on the falling system clock. It records ws and
// sd at every sck rise, counted from reset release: rise 0 is the lead-in
// period, and rise 1 + k*2*SLOT + b is bit period b of frame k.
// ---------------------------------------------------------------------------
module tb_i2s_tx;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic        rst_a, en_a, valid_a, ready_a, sck_a, ws_a, sd_a, ur_a;
  logic [23:0] left_a, right_a;
  logic        rst_b, en_b, valid_b, ready_b, sck_b, ws_b, sd_b, ur_b;
  logic [23:0] left_b, right_b;

  i2s_tx #(.WIDTH(24), .SLOT(24), .DIV(1)) dut_a (
    .clock(tb_clk), .reset(rst_a), .enable(en_a),
    .tx_left(left_a), .tx_right(right_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .sck(sck_a), .ws(ws_a), .sd(sd_a), .underrun(ur_a)
  );

  i2s_tx #(.WIDTH(24), .SLOT(32), .DIV(2)) dut_b (
    .clock(tb_clk), .reset(rst_b), .enable(en_b),
    .tx_left(left_b), .tx_right(right_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .sck(sck_b), .ws(ws_b), .sd(sd_b), .underrun(ur_b)
  );

  int checks = 0;
  int errors = 0;

  int   rise_cnt [2];
  int   clk_cnt  [2];
  logic prev_sck [2];
  logic sd_rec   [2][1024];
  logic ws_rec   [2][1024];
  int   rise_clk [2][1024];
  int   ur_frame [2][16];
  int   acc_frame[16];

  typedef struct {
    logic rst;
    logic en;
    logic valid;
    int   clocks;
    logic sck;
    logic ws;
    logic sd;
    logic ur;
    logic rdy;
  } vec_t;

  vec_t vecs[8];

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Record one DUT's outputs. It clears while that DUT is held in reset and
  // attributes each underrun pulse to the frame whose boundary caused it.
  task automatic monSample(input int i, input logic rst, input logic sck,
                           input logic ws, input logic sd, input logic ur,
                           input int frame_len);
    int f;
    if (!rst) begin
      rise_cnt[i] = 0;
      clk_cnt[i]  = 0;
      prev_sck[i] = 1'b0;
      for (int k = 0; k < 16; k++) ur_frame[i][k] = 0;
    end else begin
      clk_cnt[i]++;
      if (ur && rise_cnt[i] >= 1) begin
        f = (rise_cnt[i] - 1) / frame_len;
        if (f < 16) ur_frame[i][f]++;
      end
      if (sck && !prev_sck[i] && rise_cnt[i] < 1024) begin
        sd_rec[i][rise_cnt[i]]   = sd;
        ws_rec[i][rise_cnt[i]]   = ws;
        rise_clk[i][rise_cnt[i]] = clk_cnt[i];
        rise_cnt[i]++;
      end
      prev_sck[i] = sck;
    end
  endtask

  // Sample both DUTs away from the active clock edge.
  always @(negedge tb_clk) begin
    monSample(0, rst_a, sck_a, ws_a, sd_a, ur_a, 48);
    monSample(1, rst_b, sck_b, ws_b, sd_b, ur_b, 64);
  end

  // Wait, within a bounded number of clocks, until DUT i has shown n rises.
  task automatic waitRise(input int i, input int n, input string what);
    int budget;
    budget = 4000;
    while (rise_cnt[i] < n && budget > 0) begin
      @(negedge tb_clk);
      #1;
      budget--;
    end
    if (rise_cnt[i] < n) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout %s: rises %0d, needed %0d", what, rise_cnt[i], n);
    end
  endtask

  // Offer one pair to dut_a and hold it until accepted. This records the
  // frame in which the accept happened and checks that ready drops after it.
  task automatic sendPair(input logic [23:0] l, input logic [23:0] r);
    int budget;
    budget  = 400;
    left_a  = l;
    right_a = r;
    valid_a = 1'b1;
    while (!ready_a && budget > 0) begin
      @(negedge tb_clk);
      #1;
      budget--;
    end
    if (!ready_a) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout accept: ready 0, required 1");
      valid_a = 1'b0;
    end else begin
      if (rise_cnt[0] >= 1 && (rise_cnt[0] - 1) / 48 < 16)
        acc_frame[(rise_cnt[0] - 1) / 48]++;
      @(posedge tb_clk);
      #1;
      valid_a = 1'b0;
      checkOutput("ready after accept", 32'(ready_a), 32'h0);
    end
  endtask

  // Rebuild both slot words and the ws pattern of frame k from the record.
  task automatic checkFrame(input int i, input int k, input int S,
                            input logic [31:0] expL, input logic [31:0] expR,
                            input string tag);
    logic [31:0] l;
    logic [31:0] r;
    logic        exp_ws;
    int          base;
    int          ws_err;
    l      = '0;
    r      = '0;
    ws_err = 0;
    base   = 1 + k * 2 * S;
    for (int b = 0; b < S; b++) l = {l[30:0], sd_rec[i][base + b]};
    for (int b = S; b < 2 * S; b++) r = {r[30:0], sd_rec[i][base + b]};
    for (int b = 0; b < 2 * S; b++) begin
      exp_ws = (b >= S - 1) && (b <= 2 * S - 2);
      if (ws_rec[i][base + b] !== exp_ws) ws_err++;
    end
    checkOutput({tag, " left"}, l, expL);
    checkOutput({tag, " right"}, r, expR);
    checkOutput({tag, " ws errors"}, 32'(ws_err), 32'h0);
  endtask

  // Drive one table row, step its clocks, then compare all outputs.
  task automatic applyStimulus(input int idx, input vec_t v);
    rst_a   = v.rst;
    en_a    = v.en;
    valid_a = v.valid;
    repeat (v.clocks) @(negedge tb_clk);
    #1;
    checkOutput($sformatf("vec%0d sck", idx), 32'(sck_a), 32'(v.sck));
    checkOutput($sformatf("vec%0d ws", idx), 32'(ws_a), 32'(v.ws));
    checkOutput($sformatf("vec%0d sd", idx), 32'(sd_a), 32'(v.sd));
    checkOutput($sformatf("vec%0d underrun", idx), 32'(ur_a), 32'(v.ur));
    checkOutput($sformatf("vec%0d ready", idx), 32'(ready_a), 32'(v.rdy));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] snap;
    int          changes;
    logic [31:0] exp_ur [10];

    rst_a = 1'b0; en_a = 1'b1; valid_a = 1'b0; left_a = '0; right_a = '0;
    rst_b = 1'b0; en_b = 1'b1; valid_b = 1'b0; left_b = '0; right_b = '0;
    for (int k = 0; k < 16; k++) acc_frame[k] = 0;

    //              rst   en    valid clk sck   ws    sd    ur    rdy
    vecs[0] = '{1'b0, 1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    exp_ur = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0};

    @(negedge tb_clk);
    #1;
    for (int i = 0; i < 8; i++) applyStimulus(i, vecs[i]);

    // Streaming: pair 0 is accepted before the first boundary, then a
    // counter pair is offered continuously for frames 1..4.
    rst_a = 1'b1;
    sendPair(24'h000055, 24'hABCDEF);
    for (int n = 1; n <= 4; n++) sendPair(24'h100000 + 24'(n), 24'h200000 + 24'(n));

    // Idle frames 5..7; the next pair arrives on the frame 8 load clock.
    waitRise(0, 385, "end of frame 7");
    sendPair(24'h123456, 24'h654321);
    sendPair(24'hFFFFFF, 24'hFFFFFF);

    // Freeze in the right slot of frame 9.
    waitRise(0, 464, "frame 9 right slot");
    en_a = 1'b0;
    snap = {28'h0, sck_a, ws_a, sd_a, ur_a};
    checkOutput("freeze ws in right slot", 32'(ws_a), 32'h1);
    changes = 0;
    repeat (7) begin
      @(negedge tb_clk);
      #1;
      if ({28'h0, sck_a, ws_a, sd_a, ur_a} !== snap) changes++;
    end
    checkOutput("freeze output changes", 32'(changes), 32'h0);
    en_a = 1'b1;

    waitRise(0, 481, "end of frame 9");
    sendPair(24'hC0FFEE, 24'h0BADF0);

    checkFrame(0, 0, 24, 32'h000055, 32'hABCDEF, "frame0");
    for (int k = 1; k <= 4; k++)
      checkFrame(0, k, 24, 32'h100000 + 32'(k), 32'h200000 + 32'(k),
                 $sformatf("frame%0d", k));
    for (int k = 5; k <= 8; k++) checkFrame(0, k, 24, 32'h0, 32'h0, $sformatf("frame%0d", k));
    checkFrame(0, 9, 24, 32'h123456, 32'h654321, "frame9");
    for (int k = 0; k < 10; k++)
      checkOutput($sformatf("underruns frame%0d", k), 32'(ur_frame[0][k]), exp_ur[k]);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("accepts frame%0d", k), 32'(acc_frame[k]), 32'h1);

    // Asynchronous reset in the middle of frame 10's right slot, pair C held.
    waitRise(0, 511, "frame 10 right slot");
    checkOutput("pre-reset ws", 32'(ws_a), 32'h1);
    checkOutput("pre-reset sd", 32'(sd_a), 32'h1);
    checkOutput("pre-reset ready", 32'(ready_a), 32'h0);
    @(posedge tb_clk);
    #3;
    rst_a = 1'b0;
    #1;
    checkOutput("async reset sck", 32'(sck_a), 32'h0);
    checkOutput("async reset ws", 32'(ws_a), 32'h0);
    checkOutput("async reset sd", 32'(sd_a), 32'h0);
    checkOutput("async reset underrun", 32'(ur_a), 32'h0);
    checkOutput("async reset ready", 32'(ready_a), 32'h1);
    @(negedge tb_clk);
    #1;
    rst_a = 1'b1;
    waitRise(0, 49, "frame after reset");
    checkFrame(0, 0, 24, 32'h0, 32'h0, "post-reset frame0");
    checkOutput("post-reset underrun frame0", 32'(ur_frame[0][0]), 32'h1);
    checkOutput("post-reset ready", 32'(ready_a), 32'h1);

    // dut_b: padded slots and divided bit clock.
    @(negedge tb_clk);
    #1;
    rst_b   = 1'b1;
    left_b  = 24'hFFFFFF;
    right_b = 24'h800001;
    valid_b = 1'b1;
    @(posedge tb_clk);
    #1;
    valid_b = 1'b0;
    checkOutput("b ready after accept", 32'(ready_b), 32'h0);
    waitRise(1, 66, "dut_b frame 0");
    checkOutput("b first rise clock", 32'(rise_clk[1][0]), 32'd2);
    checkOutput("b sck period", 32'(rise_clk[1][1] - rise_clk[1][0]), 32'd4);
    checkOutput("b frame length", 32'(rise_clk[1][65] - rise_clk[1][1]), 32'd256);
    checkFrame(1, 0, 32, 32'hFFFFFF00, 32'h80000100, "b frame0");
    checkOutput("b underrun frame0", 32'(ur_frame[1][0]), 32'h0);
    checkOutput("b underrun frame1", 32'(ur_frame[1][1]), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
